ysyx_22040759_axi_rd: RTL

AXI4 read master directly downstream of the IF/MEM read arbiter. Converts the arbiter's level-held rd_addr_valid/rd_addr request into one single-beat AXI4 read (AR then R). Returns the 64-bit read word with a one-cycle rd_data_valid pulse back to the arbiter. Read-only; there is no write channel in this block.

---
 rtl/ysyx_22040759_axi_rd.sv | 117 +++++++++++
 1 files changed

// File: rtl/ysyx_22040759_axi_rd.sv
// ysyx_22040759_axi_rd: single-beat AXI4 read master between the IF/MEM read arbiter and the bus.
// Ports: clk/rst; arbiter side rd_addr_valid/rd_addr in, rd_data_valid/rd_data/rd_err out;
//        AXI AR channel (valid/ready/addr/id/len/size/burst) and R channel (valid/ready/data/resp/last/id).
// Latency: request seen -> ARVALID +1 cycle; R beat accepted -> rd_data_valid +1 cycle (3 cycles minimum).
// Backpressure: ARVALID is held until ARREADY; RREADY is high only while waiting for R.
// One read outstanding at most. Every output is a flop or a constant.
module ysyx_22040759_axi_rd #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter logic [ID_W-1:0] RD_ID = '0
) (
  input  logic              clk,
  input  logic              rst,
  // arbiter side
  input  logic              rd_addr_valid,
  input  logic [63:0]       rd_addr,
  output logic              rd_data_valid,
  output logic [63:0]       rd_data,
  output logic              rd_err,
  // AXI read address channel
  output logic              axi_ar_valid_o,
  input  logic              axi_ar_ready_i,
  output logic [ADDR_W-1:0] axi_ar_addr_o,
  output logic [ID_W-1:0]   axi_ar_id_o,
  output logic [7:0]        axi_ar_len_o,
  output logic [2:0]        axi_ar_size_o,
  output logic [1:0]        axi_ar_burst_o,
  // AXI read data channel
  input  logic              axi_r_valid_i,
  output logic              axi_r_ready_o,
  input  logic [DATA_W-1:0] axi_r_data_i,
  input  logic [1:0]        axi_r_resp_i,
  input  logic              axi_r_last_i,
  input  logic [ID_W-1:0]   axi_r_id_i
);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_AR   = 4'b0010,
    S_R    = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  state_t state;
  // Set by any discarded beat (non-last or foreign ID) of the current transaction.
  logic   sticky_err;

  // Single 64-bit beat, INCR, fixed ID.
  assign axi_ar_id_o    = RD_ID;
  assign axi_ar_len_o   = 8'd0;
  assign axi_ar_size_o  = 3'b011;
  assign axi_ar_burst_o = 2'b01;

  // Upper address bits beyond ADDR_W and RRESP[0] carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{rd_addr, axi_r_resp_i[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      sticky_err     <= 1'b0;
      axi_ar_valid_o <= 1'b0;
      axi_ar_addr_o  <= '0;
      axi_r_ready_o  <= 1'b0;
      rd_data_valid  <= 1'b0;
      rd_err         <= 1'b0;
      rd_data        <= '0;
    end else begin
      // The completion pulse lasts a single cycle unless re-armed below.
      rd_data_valid <= 1'b0;
      rd_err        <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (rd_addr_valid) begin
            axi_ar_addr_o  <= rd_addr[ADDR_W-1:0];
            axi_ar_valid_o <= 1'b1;
            state          <= S_AR;
          end
        end
        S_AR: begin
          if (axi_ar_ready_i) begin
            axi_ar_valid_o <= 1'b0;
            axi_r_ready_o  <= 1'b1;
            state          <= S_R;
          end
        end
        S_R: begin
          // RREADY is known high throughout this state, so RVALID alone marks a beat.
          if (axi_r_valid_i) begin
            if (axi_r_last_i && (axi_r_id_i == RD_ID)) begin
              rd_data       <= axi_r_data_i;
              rd_err        <= axi_r_resp_i[1] | sticky_err;
              rd_data_valid <= 1'b1;
              axi_r_ready_o <= 1'b0;
              state         <= S_DONE;
            end else begin
              sticky_err <= 1'b1;
            end
          end
        end
        S_DONE: begin
          // Requests are not sampled here; a held request is picked up in IDLE.
          sticky_err <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          axi_ar_valid_o <= 1'b0;
          axi_r_ready_o  <= 1'b0;
          sticky_err     <= 1'b0;
          state          <= S_IDLE;
        end
      endcase
    end
  end

endmodule
